// File: rtl/ldpc_bf_ctrl_if.sv
// ldpc_bf_ctrl_if
// Groups the request and result signals of the (6,3) LDPC bit-flip controller.
//   start, cw_in      : decode request and received word (bit 5 = leftmost)
//   busy, done, ok    : progress, one-cycle completion pulse, final verdict
//   cw_out            : working / corrected word
//   syndrome          : {s1,s2,s3} from the last completed check pass
//   iter_cnt          : flips performed in the current or last decode
// master drives requests (consumer side), slave is the controller.
interface ldpc_bf_ctrl_if;
   logic       start;
   logic [5:0] cw_in;
   logic       busy;
   logic       done;
   logic       ok;
   logic [5:0] cw_out;
   logic [2:0] syndrome;
   logic [3:0] iter_cnt;

   modport master (
      output start, cw_in,
      input  busy, done, ok, cw_out, syndrome, iter_cnt
   );

   modport slave (
      input  start, cw_in,
      output busy, done, ok, cw_out, syndrome, iter_cnt
   );
endinterface

// File: rtl/ldpc_bf_ctrl.sv
// ldpc_bf_ctrl
// Hard-decision bit-flipping sequencer for the (6,3) LDPC code. Parity rows
// are evaluated one per cycle through a single shared evaluator, then the
// word is flipped and rechecked until the syndrome clears or MAX_ITER flips
// have been spent.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : ldpc_bf_ctrl_if.slave (start/cw_in in; busy/done/ok/cw_out/
//            syndrome/iter_cnt out, all registered)
//
// state | meaning
// IDLE  | waiting for start, results held
// CHK0  | evaluate row h1 -> s1
// CHK1  | evaluate row h2 -> s2
// CHK2  | evaluate row h3 -> s3
// EVAL  | decide: clean, budget exhausted, or flip
// FLIP  | apply flip rule, count the iteration
// DONE  | one-cycle completion pulse
module ldpc_bf_ctrl #(
   parameter int MAX_ITER = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   ldpc_bf_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, CHK0, CHK1, CHK2, EVAL, FLIP, DONE
   } state_t;

   localparam logic [5:0] H1 = 6'b110100;
   localparam logic [5:0] H2 = 6'b011010;
   localparam logic [5:0] H3 = 6'b101001;
   localparam logic [3:0] MAX_ITER_C = 4'(MAX_ITER);

   state_t     state_q, state_d;
   logic [5:0] cw_q, cw_d;
   logic [2:0] syn_q, syn_d;
   logic [3:0] iter_q, iter_d;
   logic       ok_q, ok_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [5:0] h_row;
   logic       s_row;
   logic [2:0] cand_w2;
   logic [5:0] flip_mask;

   // Shared row evaluator: the row is selected by which check state we are in.
   always_comb begin
      h_row = H1;
      case (state_q)
         CHK1:    h_row = H2;
         CHK2:    h_row = H3;
         default: h_row = H1;
      endcase
   end

   assign s_row = ^(h_row & cw_q);

   // Weight-2 bits (5,4,3) are candidates only when both of their checks fail;
   // weight-1 bits (2,1,0) sit in exactly one check, so their candidacy is s_i.
   assign cand_w2   = {syn_q[2] & syn_q[0], syn_q[2] & syn_q[1], syn_q[1] & syn_q[0]};
   assign flip_mask = (|cand_w2) ? {cand_w2, 3'b000} : {3'b000, syn_q};

   always_comb begin
      state_d = state_q;
      cw_d    = cw_q;
      syn_d   = syn_q;
      iter_d  = iter_q;
      ok_d    = ok_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cw_d    = bus.cw_in;
               syn_d   = 3'b000;
               iter_d  = 4'd0;
               ok_d    = 1'b0;
               state_d = CHK0;
            end
         end
         CHK0: begin
            syn_d[2] = s_row;
            state_d  = CHK1;
         end
         CHK1: begin
            syn_d[1] = s_row;
            state_d  = CHK2;
         end
         CHK2: begin
            syn_d[0] = s_row;
            state_d  = EVAL;
         end
         EVAL: begin
            if (syn_q == 3'b000) begin
               ok_d    = 1'b1;
               state_d = DONE;
            end else if (iter_q == MAX_ITER_C) begin
               ok_d    = 1'b0;
               state_d = DONE;
            end else begin
               state_d = FLIP;
            end
         end
         FLIP: begin
            cw_d    = cw_q ^ flip_mask;
            iter_d  = iter_q + 4'd1;
            state_d = CHK0;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // busy/done are registered from the next state so they line up with it.
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         CHK0, CHK1, CHK2, EVAL, FLIP: busy_d = 1'b1;
         DONE:                         done_d = 1'b1;
         default: begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cw_q    <= 6'b0;
         syn_q   <= 3'b0;
         iter_q  <= 4'd0;
         ok_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cw_q    <= cw_d;
         syn_q   <= syn_d;
         iter_q  <= iter_d;
         ok_q    <= ok_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.ok       = ok_q;
   assign bus.cw_out   = cw_q;
   assign bus.syndrome = syn_q;
   assign bus.iter_cnt = iter_q;

endmodule

// File: tb/tb_ldpc_bf_ctrl.sv
module tb_ldpc_bf_ctrl;

   localparam int MI = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   ldpc_bf_ctrl_if bus ();

   ldpc_bf_ctrl #(.MAX_ITER(MI)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Decoder reference: plain iterative bit flipping straight from H.
   function automatic void model_decode(input logic [5:0] cw, output logic ok,
                                        output logic [5:0] co, output logic [2:0] so,
                                        output int it);
      logic [5:0] h [3];
      logic [5:0] w;
      logic [2:0] s;
      logic [5:0] cand;
      logic [5:0] mask;
      int wts [6];
      int un;
      int maxw;
      h[0] = 6'b110100;
      h[1] = 6'b011010;
      h[2] = 6'b101001;
      for (int j = 0; j < 6; j++) begin
         wts[j] = 0;
         for (int r = 0; r < 3; r++) if (h[r][j]) wts[j]++;
      end
      w  = cw;
      it = 0;
      ok = 0;
      s  = 0;
      for (int g = 0; g <= MI + 1; g++) begin
         for (int r = 0; r < 3; r++) s[2-r] = ^(h[r] & w);
         if (s == 3'b000) begin ok = 1; break; end
         if (it == MI) begin ok = 0; break; end
         cand = 0;
         maxw = 0;
         for (int j = 0; j < 6; j++) begin
            un = 0;
            for (int r = 0; r < 3; r++) if (h[r][j] && s[2-r]) un++;
            if (un == wts[j]) begin
               cand[j] = 1;
               if (wts[j] > maxw) maxw = wts[j];
            end
         end
         mask = 0;
         for (int j = 0; j < 6; j++) if (cand[j] && wts[j] == maxw) mask[j] = 1;
         w = w ^ mask;
         it++;
      end
      co = w;
      so = s;
   endfunction

   // Model timeline: edges counted from the accepting edge.
   bit         m_active = 0;
   int         m_cnt = 0;
   int         m_n = 0;
   logic       m_ok = 0;
   logic [5:0] m_cw = 0;
   logic [2:0] m_syn = 0;
   int         m_it = 0;
   logic       p_ok;
   logic [5:0] p_cw;
   logic [2:0] p_syn;
   int         p_it;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_cnt = 0; m_n = 0;
         m_ok = 0; m_cw = 0; m_syn = 0; m_it = 0;
      end else if (!m_active) begin
         if (bus.start) begin
            model_decode(bus.cw_in, p_ok, p_cw, p_syn, p_it);
            m_n      = 4 + 5 * p_it;
            m_cnt    = 0;
            m_active = 1;
         end
      end else begin
         m_cnt++;
         if (m_cnt == m_n) begin
            m_ok = p_ok; m_cw = p_cw; m_syn = p_syn; m_it = p_it;
         end
         if (m_cnt == m_n + 1) m_active = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit e_busy, e_done;
         e_busy = m_active && (m_cnt < m_n);
         e_done = m_active && (m_cnt == m_n);
         chk("cmp_busy", int'(bus.busy), int'(e_busy));
         chk("cmp_done", int'(bus.done), int'(e_done));
         if (!m_active || e_done) begin
            chk("cmp_ok", int'(bus.ok), int'(m_ok));
            chk("cmp_cw_out", int'(bus.cw_out), int'(m_cw));
            chk("cmp_syndrome", int'(bus.syndrome), int'(m_syn));
            chk("cmp_iter_cnt", int'(bus.iter_cnt), m_it);
         end
      end
   end

   task automatic run(input logic [5:0] cw, input logic eok, input logic [5:0] ecw,
                      input logic [2:0] esyn, input int eit, input int ecyc, input bit poke);
      int cyc;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.cw_in = cw;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.cw_in = 6'b0;
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (bus.done) seen = 1;
         if (poke && cyc == 2) begin
            bus.start = 1'b1;
            bus.cw_in = ~cw;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      chk("done_seen", int'(seen), 1);
      chk("done_cycles", cyc, ecyc);
      chk("lit_ok", int'(bus.ok), int'(eok));
      chk("lit_cw_out", int'(bus.cw_out), int'(ecw));
      chk("lit_syndrome", int'(bus.syndrome), int'(esyn));
      chk("lit_iter_cnt", int'(bus.iter_cnt), eit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int pulses;
      bit seen;
      bus.start = 1'b0;
      bus.cw_in = 6'b0;
      #1 rst_n = 1'b0;
      #1 chk_en = 1;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_cw_out", int'(bus.cw_out), 0);
      chk("rst_iter", int'(bus.iter_cnt), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(6'b001011, 1'b1, 6'b001011, 3'b000, 0, 4, 0);  @(posedge clk);
      run(6'b001010, 1'b1, 6'b001011, 3'b000, 1, 9, 0);  @(posedge clk);
      run(6'b001000, 1'b1, 6'b000000, 3'b000, 1, 9, 0);  @(posedge clk);
      run(6'b100000, 1'b1, 6'b000000, 3'b000, 1, 9, 0);  @(posedge clk);
      run(6'b000100, 1'b1, 6'b000000, 3'b000, 1, 9, 0);  @(posedge clk);
      run(6'b000111, 1'b0, 6'b000111, 3'b111, 4, 24, 0); @(posedge clk);
      // second start while busy must be ignored
      run(6'b001010, 1'b1, 6'b001011, 3'b000, 1, 9, 1);  @(posedge clk);

      // reset asserted while in FLIP aborts with no done pulse
      @(negedge clk);
      bus.start = 1'b1;
      bus.cw_in = 6'b001010;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("flip_busy", int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_cw_out", int'(bus.cw_out), 0);
      chk("abort_syndrome", int'(bus.syndrome), 0);
      chk("abort_iter", int'(bus.iter_cnt), 0);
      chk("abort_ok", int'(bus.ok), 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) pulses++;
      end
      chk("abort_no_done", pulses, 0);
      run(6'b011101, 1'b1, 6'b011101, 3'b000, 0, 4, 0);

      // back-to-back: start held through DONE, accepted once IDLE is reached
      bus.start = 1'b1;
      bus.cw_in = 6'b001000;
      @(posedge clk);
      #1;
      chk("b2b_ignored_in_done", int'(bus.busy), 0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("b2b_accepted", int'(bus.busy), 1);
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (bus.done) seen = 1;
      end
      chk("b2b_done_seen", int'(seen), 1);
      chk("b2b_cycles", cyc, 9);
      chk("b2b_cw_out", int'(bus.cw_out), 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
